// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The datapath (master) reports decode/execute/memory status; the controller
// (slave) returns register enables, squash controls and statistics.
interface pipeline_hazard_ctrl_if;
   logic        id_ex_mem_read;
   logic [4:0]  id_ex_rd;
   logic [4:0]  if_id_rs1;
   logic [4:0]  if_id_rs2;
   logic        if_id_uses_rs2;
   logic        branch_taken;
   logic        dmem_req;
   logic        dmem_ready;
   logic        pc_write;
   logic        if_id_write;
   logic        id_ex_write;
   logic        ex_mem_write;
   logic        id_ex_bubble;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        err;
   logic [15:0] stall_cnt;
   logic [7:0]  flush_cnt;

   modport master (
      output id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2, if_id_uses_rs2,
             branch_taken, dmem_req, dmem_ready,
      input  pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
             if_id_flush, id_ex_flush, err, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2, if_id_uses_rs2,
             branch_taken, dmem_req, dmem_ready,
      output pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
             if_id_flush, id_ex_flush, err, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Resolves load-use stalls, memory-wait freezes, taken-branch flushes and a
// sticky memory-timeout error. Control outputs are combinational from the
// registered state and the current inputs; statistics counters saturate.
module pipeline_hazard_ctrl #(
   parameter int LDSTALL_CYCLES = 1,   // load-use bubble length, 1..4
   parameter int WAIT_TIMEOUT   = 255  // MEMWAIT cycle index that trips ERROR, 1..255
) (
   input  logic                  clk,
   input  logic                  arst,
   pipeline_hazard_ctrl_if.slave hif
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LDSTALL = 2'd1,
      ST_MEMWAIT = 2'd2,
      ST_ERROR   = 2'd3
   } state_t;

   // Remaining bubble cycles after the one in which the hazard is detected.
   localparam logic [1:0] LD_RELOAD  = 2'(LDSTALL_CYCLES - 1);
   localparam bit         LD_MULTI   = (LDSTALL_CYCLES > 1);
   localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_TIMEOUT);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t      state_q, state_d;
   logic [1:0]  ld_cnt_q, ld_cnt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [7:0]  flush_cnt_q, flush_cnt_d;

   logic hz;
   logic mw;
   logic freeze;
   logic run_eval;
   logic pc_we, ifid_we, idex_we, exmem_we;
   logic bubble, ifid_fl, idex_fl;

   // The OR of the two source matches sits inside the AND so that a load to x0
   // or a non-load never stalls regardless of which source matches.
   assign hz = hif.id_ex_mem_read & (hif.id_ex_rd != 5'd0) &
               ((hif.id_ex_rd == hif.if_id_rs1) |
                (hif.if_id_uses_rs2 & (hif.id_ex_rd == hif.if_id_rs2)));

   assign mw = hif.dmem_req & ~hif.dmem_ready;

   // Next-state and control decode; priority is ERROR > mw > branch > hz.
   always_comb begin
      state_d    = state_q;
      ld_cnt_d   = ld_cnt_q;
      wait_cnt_d = wait_cnt_q;
      freeze     = 1'b0;
      run_eval   = 1'b0;
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      idex_we    = 1'b1;
      exmem_we   = 1'b1;
      bubble     = 1'b0;
      ifid_fl    = 1'b0;
      idex_fl    = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mw) begin
               freeze     = 1'b1;
               wait_cnt_d = 8'd1;
               state_d    = ST_MEMWAIT;
            end else begin
               run_eval = 1'b1;
            end
         end
         ST_LDSTALL: begin
            if (mw) begin
               // A memory wait abandons the rest of the load-use bubble.
               freeze     = 1'b1;
               ld_cnt_d   = 2'd0;
               wait_cnt_d = 8'd1;
               state_d    = ST_MEMWAIT;
            end else if (hif.branch_taken) begin
               ifid_fl  = 1'b1;
               idex_fl  = 1'b1;
               ld_cnt_d = 2'd0;
               state_d  = ST_RUN;
            end else begin
               pc_we    = 1'b0;
               ifid_we  = 1'b0;
               bubble   = 1'b1;
               ld_cnt_d = ld_cnt_q - 2'd1;
               if (ld_cnt_q == 2'd1) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_MEMWAIT: begin
            if (mw) begin
               // wait_cnt_q is the index of the current MEMWAIT cycle.
               freeze = 1'b1;
               if (wait_cnt_q == WAIT_LIMIT) begin
                  state_d = ST_ERROR;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end else begin
               // Release cycle behaves exactly like a RUN cycle.
               wait_cnt_d = 8'd0;
               state_d    = ST_RUN;
               run_eval   = 1'b1;
            end
         end
         default: begin
            freeze = 1'b1;
         end
      endcase

      if (run_eval) begin
         if (hif.branch_taken) begin
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
         end else if (hz) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            bubble  = 1'b1;
            if (LD_MULTI) begin
               ld_cnt_d = LD_RELOAD;
               state_d  = ST_LDSTALL;
            end
         end
      end

      if (freeze) begin
         pc_we    = 1'b0;
         ifid_we  = 1'b0;
         idex_we  = 1'b0;
         exmem_we = 1'b0;
      end
   end

   // Statistics: count every cycle the PC is held and every flush issued.
   always_comb begin
      stall_cnt_d = pc_we ? stall_cnt_q : sat_inc16(stall_cnt_q);
      flush_cnt_d = ifid_fl ? sat_inc8(flush_cnt_q) : flush_cnt_q;
   end

   // State and counter registers; reset aborts any stall or wait in progress.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= ST_RUN;
         ld_cnt_q    <= 2'd0;
         wait_cnt_q  <= 8'd0;
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         ld_cnt_q    <= ld_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hif.pc_write     = pc_we;
   assign hif.if_id_write  = ifid_we;
   assign hif.id_ex_write  = idex_we;
   assign hif.ex_mem_write = exmem_we;
   assign hif.id_ex_bubble = bubble;
   assign hif.if_id_flush  = ifid_fl;
   assign hif.id_ex_flush  = idex_fl;
   assign hif.err          = (state_q == ST_ERROR);
   assign hif.stall_cnt    = stall_cnt_q;
   assign hif.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (1-cycle and 3-cycle load-use
// bubbles, different timeouts) share one stimulus stream. Directed scenarios
// check fixed expectations; a randomized run checks against a cycle model.
module tb_pipeline_hazard_ctrl;
   localparam int A_LD = 1, A_TO = 4;
   localparam int B_LD = 3, B_TO = 6;

   logic clk  = 1'b0;
   logic arst = 1'b1;
   always #5 clk = ~clk;

   logic       r_mr, r_u2, r_br, r_req, r_rdy;
   logic [4:0] r_rd, r_rs1, r_rs2;

   pipeline_hazard_ctrl_if ifa ();
   pipeline_hazard_ctrl_if ifb ();

   assign ifa.id_ex_mem_read = r_mr;
   assign ifa.id_ex_rd       = r_rd;
   assign ifa.if_id_rs1      = r_rs1;
   assign ifa.if_id_rs2      = r_rs2;
   assign ifa.if_id_uses_rs2 = r_u2;
   assign ifa.branch_taken   = r_br;
   assign ifa.dmem_req       = r_req;
   assign ifa.dmem_ready     = r_rdy;
   assign ifb.id_ex_mem_read = r_mr;
   assign ifb.id_ex_rd       = r_rd;
   assign ifb.if_id_rs1      = r_rs1;
   assign ifb.if_id_rs2      = r_rs2;
   assign ifb.if_id_uses_rs2 = r_u2;
   assign ifb.branch_taken   = r_br;
   assign ifb.dmem_req       = r_req;
   assign ifb.dmem_ready     = r_rdy;

   pipeline_hazard_ctrl #(.LDSTALL_CYCLES(A_LD), .WAIT_TIMEOUT(A_TO)) dut_a (
      .clk(clk), .arst(arst), .hif(ifa));
   pipeline_hazard_ctrl #(.LDSTALL_CYCLES(B_LD), .WAIT_TIMEOUT(B_TO)) dut_b (
      .clk(clk), .arst(arst), .hif(ifb));

   // {pc, if_id_we, id_ex_we, ex_mem_we, bubble, if_id_flush, id_ex_flush, err}
   logic [7:0] flags_a, flags_b;
   assign flags_a = {ifa.pc_write, ifa.if_id_write, ifa.id_ex_write, ifa.ex_mem_write,
                     ifa.id_ex_bubble, ifa.if_id_flush, ifa.id_ex_flush, ifa.err};
   assign flags_b = {ifb.pc_write, ifb.if_id_write, ifb.id_ex_write, ifb.ex_mem_write,
                     ifb.id_ex_bubble, ifb.if_id_flush, ifb.id_ex_flush, ifb.err};

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: bubbles still owed, wait-cycle index, waiting/dead flags.
   int         m_bub[2], m_wait[2], m_stalls[2], m_flushes[2];
   bit         m_waiting[2], m_dead[2];
   int         n_bub[2], n_wait[2], n_stalls[2], n_flushes[2];
   bit         n_waiting[2], n_dead[2];
   logic [7:0] e_flags[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_bub[k] = 0; m_wait[k] = 0; m_stalls[k] = 0; m_flushes[k] = 0;
         m_waiting[k] = 1'b0; m_dead[k] = 1'b0;
      end
   endtask

   task automatic model_eval();
      for (int k = 0; k < 2; k++) begin
         int ld;
         int to;
         bit hz, mw, pc, ifw, idw, exw, bub, fl;
         ld = (k == 0) ? A_LD : B_LD;
         to = (k == 0) ? A_TO : B_TO;
         hz = r_mr && (r_rd != 0) && ((r_rd == r_rs1) || (r_u2 && (r_rd == r_rs2)));
         mw = r_req && !r_rdy;
         pc = 1; ifw = 1; idw = 1; exw = 1; bub = 0; fl = 0;
         n_bub[k] = m_bub[k]; n_wait[k] = m_wait[k];
         n_waiting[k] = m_waiting[k]; n_dead[k] = m_dead[k];
         if (m_dead[k]) begin
            pc = 0; ifw = 0; idw = 0; exw = 0;
         end else if (mw) begin
            pc = 0; ifw = 0; idw = 0; exw = 0;
            n_bub[k] = 0;
            if (!m_waiting[k]) begin
               n_waiting[k] = 1; n_wait[k] = 1;
            end else if (m_wait[k] >= to) begin
               n_dead[k] = 1;
            end else begin
               n_wait[k] = m_wait[k] + 1;
            end
         end else begin
            n_waiting[k] = 0;
            if (r_br) begin
               fl = 1; n_bub[k] = 0;
            end else if (m_bub[k] > 0) begin
               pc = 0; ifw = 0; bub = 1; n_bub[k] = m_bub[k] - 1;
            end else if (hz) begin
               pc = 0; ifw = 0; bub = 1; n_bub[k] = ld - 1;
            end
         end
         e_flags[k]   = {pc, ifw, idw, exw, bub, fl, fl, m_dead[k]};
         n_stalls[k]  = pc ? m_stalls[k] : ((m_stalls[k] < 65535) ? m_stalls[k] + 1 : 65535);
         n_flushes[k] = fl ? ((m_flushes[k] < 255) ? m_flushes[k] + 1 : 255) : m_flushes[k];
      end
   endtask

   task automatic model_commit();
      for (int k = 0; k < 2; k++) begin
         m_bub[k] = n_bub[k]; m_wait[k] = n_wait[k];
         m_waiting[k] = n_waiting[k]; m_dead[k] = n_dead[k];
         m_stalls[k] = n_stalls[k]; m_flushes[k] = n_flushes[k];
      end
   endtask

   task automatic apply(input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input bit u2, input bit br,
                        input bit req, input bit rdy);
      r_mr = mr; r_rd = rd; r_rs1 = rs1; r_rs2 = rs2;
      r_u2 = u2; r_br = br; r_req = req; r_rdy = rdy;
      #1;
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      #1;
      model_eval();
   endtask

   task automatic do_reset();
      r_mr = 0; r_rd = 0; r_rs1 = 0; r_rs2 = 0; r_u2 = 0; r_br = 0; r_req = 0; r_rdy = 0;
      arst = 1'b1;
      #1;
      model_reset();
      @(posedge clk);
      #2;
      arst = 1'b0;
      #1;
      model_eval();
   endtask

   task automatic test_reset();
      do_reset();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (ifa.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall: got %0d want 0", ifa.stall_cnt); end
      n_cmp++; if (ifa.flush_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_flush: got %0d want 0", ifa.flush_cnt); end
      n_cmp++; if (flags_a !== 8'b1111_0000) begin n_fail++; $display("FAIL rst_idle_flags: got %b want 11110000", flags_a); end
      apply(1, 5, 5, 0, 0, 0, 0, 0);
      tick();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (ifb.pc_write !== 1'b0) begin n_fail++; $display("FAIL rst_pre_ldstall: got %b want 0", ifb.pc_write); end
      arst = 1'b1;
      #1;
      n_cmp++; if (ifa.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_async_a: got %0d want 0", ifa.stall_cnt); end
      n_cmp++; if (ifb.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_async_b: got %0d want 0", ifb.stall_cnt); end
      n_cmp++; if (flags_b !== 8'b1111_0000) begin n_fail++; $display("FAIL rst_abort_ldstall: got %b want 11110000", flags_b); end
      do_reset();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++; if (flags_b !== 8'b1111_0000) begin n_fail++; $display("FAIL rst_after_release: got %b want 11110000", flags_b); end
   endtask

   task automatic test_load_use();
      do_reset();
      apply(1, 5, 5, 0, 0, 0, 0, 0);
      n_cmp++; if (flags_a !== 8'b0011_1000) begin n_fail++; $display("FAIL lu_stall_a: got %b want 00111000", flags_a); end
      n_cmp++; if (flags_b !== 8'b0011_1000) begin n_fail++; $display("FAIL lu_stall_b: got %b want 00111000", flags_b); end
      tick();
      apply(0, 0, 5, 0, 0, 0, 0, 0);
      n_cmp++; if (flags_a !== 8'b1111_0000) begin n_fail++; $display("FAIL lu_release_a: got %b want 11110000", flags_a); end
      n_cmp++; if (ifa.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_a: got %0d want 1", ifa.stall_cnt); end
      n_cmp++; if (flags_b !== 8'b0011_1000) begin n_fail++; $display("FAIL lu_ldstall_b1: got %b want 00111000", flags_b); end
      tick();
      apply(0, 0, 5, 0, 0, 0, 0, 0);
      n_cmp++; if (flags_b !== 8'b0011_1000) begin n_fail++; $display("FAIL lu_ldstall_b2: got %b want 00111000", flags_b); end
      tick();
      apply(0, 0, 5, 0, 0, 0, 0, 0);
      n_cmp++; if (flags_b !== 8'b1111_0000) begin n_fail++; $display("FAIL lu_release_b: got %b want 11110000", flags_b); end
      n_cmp++; if (ifb.stall_cnt !== 16'd3) begin n_fail++; $display("FAIL lu_cnt_b: got %0d want 3", ifb.stall_cnt); end
      n_cmp++; if (ifa.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_a_hold: got %0d want 1", ifa.stall_cnt); end
   endtask

   task automatic test_no_stall();
      do_reset();
      apply(1, 0, 0, 0, 1, 0, 0, 0);
      n_cmp++; if (flags_a !== 8'b1111_0000) begin n_fail++; $display("FAIL x0_rs1: got %b want 11110000", flags_a); end
      tick();
      apply(1, 7, 3, 7, 0, 0, 0, 0);
      n_cmp++; if (flags_a !== 8'b1111_0000) begin n_fail++; $display("FAIL rs2_unused: got %b want 11110000", flags_a); end
      tick();
      apply(1, 7, 3, 7, 1, 0, 0, 0);
      n_cmp++; if (flags_a !== 8'b0011_1000) begin n_fail++; $display("FAIL rs2_used: got %b want 00111000", flags_a); end
      apply(0, 7, 7, 7, 1, 0, 0, 0);
      n_cmp++; if (flags_a !== 8'b1111_0000) begin n_fail++; $display("FAIL not_load: got %b want 11110000", flags_a); end
   endtask

   task automatic test_mem_wait();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 0, 0, 0, 0, 1, 0);
         n_cmp++; if (flags_a !== 8'b0000_0000) begin n_fail++; $display("FAIL mw_freeze[%0d]: got %b want 00000000", i, flags_a); end
         tick();
      end
      apply(0, 0, 0, 0, 0, 0, 1, 1);
      n_cmp++; if (flags_a !== 8'b1111_0000) begin n_fail++; $display("FAIL mw_release: got %b want 11110000", flags_a); end
      tick();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (ifa.stall_cnt !== 16'd3) begin n_fail++; $display("FAIL mw_cnt: got %0d want 3", ifa.stall_cnt); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      apply(1, 5, 5, 0, 0, 1, 0, 0);
      n_cmp++; if (flags_a !== 8'b1111_0110) begin n_fail++; $display("FAIL br_hz_a: got %b want 11110110", flags_a); end
      n_cmp++; if (flags_b !== 8'b1111_0110) begin n_fail++; $display("FAIL br_hz_b: got %b want 11110110", flags_b); end
      tick();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (ifa.flush_cnt !== 8'd1) begin n_fail++; $display("FAIL br_cnt: got %0d want 1", ifa.flush_cnt); end
      n_cmp++; if (flags_b !== 8'b1111_0000) begin n_fail++; $display("FAIL br_no_ldstall_b: got %b want 11110000", flags_b); end
      apply(0, 0, 0, 0, 0, 1, 1, 0);
      n_cmp++; if (flags_a !== 8'b0000_0000) begin n_fail++; $display("FAIL mw_br_freeze: got %b want 00000000", flags_a); end
      tick();
      apply(0, 0, 0, 0, 0, 1, 1, 1);
      n_cmp++; if (flags_a !== 8'b1111_0110) begin n_fail++; $display("FAIL mw_br_release: got %b want 11110110", flags_a); end
      tick();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (ifa.flush_cnt !== 8'd2) begin n_fail++; $display("FAIL mw_br_cnt: got %0d want 2", ifa.flush_cnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      apply(0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (ifa.err !== 1'b0) begin n_fail++; $display("FAIL to_early_err[%0d]: got %b want 0", i, ifa.err); end
         tick();
      end
      n_cmp++; if (flags_a !== 8'b0000_0001) begin n_fail++; $display("FAIL to_error: got %b want 00000001", flags_a); end
      n_cmp++; if (ifb.err !== 1'b0) begin n_fail++; $display("FAIL to_b_not_yet: got %b want 0", ifb.err); end
      apply(1, 5, 5, 0, 0, 1, 0, 0);
      n_cmp++; if (flags_a !== 8'b0000_0001) begin n_fail++; $display("FAIL to_sticky: got %b want 00000001", flags_a); end
      tick();
      apply(0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      tick();
      r_req = 1'b0;
      arst  = 1'b1;
      #1;
      n_cmp++; if (flags_a !== 8'b1111_0000) begin n_fail++; $display("FAIL to_rst_a: got %b want 11110000", flags_a); end
      n_cmp++; if (flags_b !== 8'b1111_0000) begin n_fail++; $display("FAIL to_rst_mid_wait_b: got %b want 11110000", flags_b); end
      do_reset();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++; if (flags_a !== 8'b1111_0000) begin n_fail++; $display("FAIL to_after_rst: got %b want 11110000", flags_a); end
   endtask

   task automatic test_saturation();
      do_reset();
      apply(0, 0, 0, 0, 0, 0, 1, 0);
      repeat (70000) tick();
      n_cmp++; if (ifa.stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_stall_a: got %h want ffff", ifa.stall_cnt); end
      n_cmp++; if (ifb.stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_stall_b: got %h want ffff", ifb.stall_cnt); end
      do_reset();
      apply(0, 0, 0, 0, 0, 1, 0, 0);
      repeat (254) tick();
      n_cmp++; if (ifa.flush_cnt !== 8'd254) begin n_fail++; $display("FAIL flush_pre_sat: got %0d want 254", ifa.flush_cnt); end
      repeat (46) tick();
      n_cmp++; if (ifa.flush_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_flush_a: got %h want ff", ifa.flush_cnt); end
      n_cmp++; if (ifb.flush_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_flush_b: got %h want ff", ifb.flush_cnt); end
   endtask

   task automatic test_random();
      int burst;
      burst = 0;
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         bit req, rdy;
         if ($urandom_range(0, 149) == 0) begin
            arst = 1'b1;
            #1;
            n_cmp++; if ({ifa.stall_cnt, ifb.flush_cnt, ifa.err, ifb.err} !== 26'd0) begin
               n_fail++; $display("FAIL rand_rst cyc %0d: got %h/%h/%b%b want 0", cyc, ifa.stall_cnt, ifb.flush_cnt, ifa.err, ifb.err);
            end
            do_reset();
            continue;
         end
         if (burst > 0) begin
            req = 1; rdy = 0; burst--;
         end else if ($urandom_range(0, 40) == 0) begin
            req = 1; rdy = 0; burst = int'($urandom_range(3, 8));
         end else begin
            req = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 1) == 0);
         end
         apply(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), req, rdy);
         for (int k = 0; k < 2; k++) begin
            logic [7:0]  got_f;
            logic [15:0] got_s;
            logic [7:0]  got_c;
            got_f = (k == 0) ? flags_a : flags_b;
            got_s = (k == 0) ? ifa.stall_cnt : ifb.stall_cnt;
            got_c = (k == 0) ? ifa.flush_cnt : ifb.flush_cnt;
            n_cmp++; if (got_f !== e_flags[k]) begin n_fail++; $display("FAIL rand_flags[%0d] cyc %0d: got %b want %b", k, cyc, got_f, e_flags[k]); end
            n_cmp++; if (got_s !== 16'(m_stalls[k])) begin n_fail++; $display("FAIL rand_stall[%0d] cyc %0d: got %0d want %0d", k, cyc, got_s, m_stalls[k]); end
            n_cmp++; if (got_c !== 8'(m_flushes[k])) begin n_fail++; $display("FAIL rand_flush[%0d] cyc %0d: got %0d want %0d", k, cyc, got_c, m_flushes[k]); end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_stall();
      test_mem_wait();
      test_simultaneous();
      test_timeout();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
